bcd_convert_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using double-dabble (shift-add-3). It performs one shift iteration per clock, with a start/ready/done handshake, so wide inputs do not produce a long combinational chain. It adds saturation on overflow and leading-zero blanking flags. It sits between binary counters/ALU results and the 7-segment display drivers.

---
 rtl/bcd_convert_seq.sv | 144 ++++++++++++++
 tb/tb_bcd_convert_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_seq.sv
`default_nettype none
// ============================================================================
// Module  : bcd_convert_seq
// Brief   : Sequential double-dabble binary-to-BCD converter, one shift per
//           clock, with overflow saturation and leading-zero blank flags.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_convert_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    function automatic logic [63:0] f_pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam int              c_cw        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cw-1:0] c_last      = c_cw'(WIDTH - 1);
    localparam logic [63:0]     c_max_dec   = f_pow10(DIGITS) - 64'd1;
    localparam logic [63:0]     c_max_bin   = (64'd1 << WIDTH) - 64'd1;
    localparam logic [DIGITS-1:0] c_blank_rst = ~DIGITS'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [WIDTH-1:0]    r_sh;
    logic [4*DIGITS-1:0] r_acc;
    logic [c_cw-1:0]     r_cnt;
    logic                r_ovf_pend;
    logic                w_ovf;
    logic [4*DIGITS-1:0] w_adj;
    logic [4*DIGITS-1:0] w_acc_next;
    logic [WIDTH-1:0]    w_sh_next;
    logic                w_carry_unused;
    logic [4*DIGITS-1:0] w_bcd_final;
    logic [DIGITS-1:0]   w_blank;

    // Overflow is impossible when the widest input still fits the digit count.
    generate
        if (c_max_bin <= c_max_dec) begin : g_no_ovf
            assign w_ovf = 1'b0;
        end else begin : g_ovf
            logic [63:0] w_bin_ext;
            assign w_bin_ext = {{(64-WIDTH){1'b0}}, bin};
            assign w_ovf     = (w_bin_ext > c_max_dec);
        end
    endgenerate

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? r_acc[4*i +: 4] + 4'd3
                                                       : r_acc[4*i +: 4];
        end
    end

    assign {w_carry_unused, w_acc_next, w_sh_next} = {w_adj, r_sh, 1'b0};
    assign w_bcd_final = r_ovf_pend ? {DIGITS{4'd9}} : w_acc_next;

    // Blanking follows the displayed value, so a saturated result never blanks.
    always_comb begin
        w_blank = '0;
        for (int i = 1; i < DIGITS; i++) begin
            w_blank[i] = ((w_bcd_final >> (4*i)) == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_state_next = S_CONV;
            end
            S_CONV: begin
                if (r_cnt == c_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
            blank      <= c_blank_rst;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sh       <= bin;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= w_ovf;
                    end
                end
                S_CONV: begin
                    r_sh  <= w_sh_next;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        bcd      <= w_bcd_final;
                        overflow <= r_ovf_pend;
                        blank    <= w_blank;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_convert_seq
// Brief   : Self-checking bench for bcd_convert_seq across three configurations.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_convert_seq;

    localparam int PW [3] = '{8, 8, 5};
    localparam int PD [3] = '{3, 2, 2};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st [3];
    logic [31:0] bv [3];

    logic        a_ready [3];
    logic        a_done  [3];
    logic        a_ovf   [3];
    logic [39:0] a_bcd   [3];
    logic [9:0]  a_blank [3];

    logic [11:0] bcd0;
    logic [7:0]  bcd1, bcd2;
    logic [2:0]  blank0;
    logic [1:0]  blank1, blank2;

    int checks = 0;
    int failures = 0;

    // Model state: cycles left until idle, pending and visible expectations.
    int          mcnt  [3];
    logic [39:0] pbcd  [3], ebcd  [3];
    logic        povf  [3], eovf  [3];
    logic [9:0]  pblk  [3], eblank[3];

    always #5 clk = ~clk;

    bcd_convert_seq #(.WIDTH(8), .DIGITS(3)) u_d0 (
        .clk(clk), .reset(reset), .start(st[0]), .bin(bv[0][7:0]),
        .ready(a_ready[0]), .done(a_done[0]), .bcd(bcd0), .overflow(a_ovf[0]), .blank(blank0));
    bcd_convert_seq #(.WIDTH(8), .DIGITS(2)) u_d1 (
        .clk(clk), .reset(reset), .start(st[1]), .bin(bv[1][7:0]),
        .ready(a_ready[1]), .done(a_done[1]), .bcd(bcd1), .overflow(a_ovf[1]), .blank(blank1));
    bcd_convert_seq #(.WIDTH(5), .DIGITS(2)) u_d2 (
        .clk(clk), .reset(reset), .start(st[2]), .bin(bv[2][4:0]),
        .ready(a_ready[2]), .done(a_done[2]), .bcd(bcd2), .overflow(a_ovf[2]), .blank(blank2));

    assign a_bcd[0] = 40'(bcd0);
    assign a_bcd[1] = 40'(bcd1);
    assign a_bcd[2] = 40'(bcd2);
    assign a_blank[0] = 10'(blank0);
    assign a_blank[1] = 10'(blank1);
    assign a_blank[2] = 10'(blank2);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic ovf_of(input logic [63:0] v, input int d);
        return v > pow10(d) - 1;
    endfunction

    function automatic logic [39:0] res_of(input logic [63:0] v, input int d);
        logic [39:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = ovf_of(v, d) ? 4'd9 : 4'((v / pow10(i)) % 10);
        end
        return r;
    endfunction

    function automatic logic [9:0] blk_of(input logic [63:0] v, input int d);
        logic [9:0] r = '0;
        for (int i = 1; i < d; i++) r[i] = !ovf_of(v, d) && (v < pow10(i));
        return r;
    endfunction

    function automatic logic [9:0] rst_blank(input int d);
        logic [9:0] r = '0;
        for (int i = 1; i < d; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] masked(input logic [31:0] v, input int w);
        return 64'(v) & ((64'd1 << w) - 1);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mcnt[k]   <= 0;
                ebcd[k]   <= '0;
                eovf[k]   <= 1'b0;
                eblank[k] <= rst_blank(PD[k]);
            end else if (mcnt[k] == 0) begin
                if (st[k]) begin
                    mcnt[k] <= PW[k] + 1;
                    pbcd[k] <= res_of(masked(bv[k], PW[k]), PD[k]);
                    povf[k] <= ovf_of(masked(bv[k], PW[k]), PD[k]);
                    pblk[k] <= blk_of(masked(bv[k], PW[k]), PD[k]);
                end
            end else begin
                mcnt[k] <= mcnt[k] - 1;
                if (mcnt[k] == 2) begin
                    ebcd[k]   <= pbcd[k];
                    eovf[k]   <= povf[k];
                    eblank[k] <= pblk[k];
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("ready", k, 64'(a_ready[k]), 64'(mcnt[k] == 0));
            chk("done",  k, 64'(a_done[k]),  64'(mcnt[k] == 1));
            chk("bcd",   k, 64'(a_bcd[k]),   64'(ebcd[k]));
            chk("ovf",   k, 64'(a_ovf[k]),   64'(eovf[k]));
            chk("blank", k, 64'(a_blank[k]), 64'(eblank[k]));
        end
    end

    task automatic run(input int k, input logic [31:0] v, input logic [39:0] xb,
                       input logic xo, input logic [9:0] xbl);
        int  n = 0;
        bit  seen = 0;
        @(negedge clk); #1 st[k] = 1'b1; bv[k] = v;
        @(negedge clk); #1 st[k] = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = a_done[k];
        end
        chk("done_seen", k, 64'(seen), 64'd1);
        chk("latency",   k, 64'(n), 64'(PW[k]));
        chk("bcd_lit",   k, 64'(a_bcd[k]), 64'(xb));
        chk("ovf_lit",   k, 64'(a_ovf[k]), 64'(xo));
        chk("blank_lit", k, 64'(a_blank[k]), 64'(xbl));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        for (int k = 0; k < 3; k++) begin st[k] = 1'b0; bv[k] = '0; end
        repeat (2) @(negedge clk);
        chk("rst_ready", 0, 64'(a_ready[0]), 64'd1);
        chk("rst_blank", 0, 64'(a_blank[0]), 64'b110);
        #1 reset = 1'b0;

        run(0, 255, 40'h255, 1'b0, 10'b000);
        run(0,   0, 40'h000, 1'b0, 10'b110);
        run(0,   7, 40'h007, 1'b0, 10'b110);
        run(0,  40, 40'h040, 1'b0, 10'b100);

        run(1, 123, 40'h99, 1'b1, 10'b00);
        run(1,  99, 40'h99, 1'b0, 10'b00);
        run(1, 100, 40'h99, 1'b1, 10'b00);

        for (int v = 0; v < 32; v++) run(2, v, res_of(64'(v), 2), 1'b0, blk_of(64'(v), 2));
        run(2, 31, 40'h31, 1'b0, 10'b00);

        // Starts during CONV and DONE carry a different value and must be dropped.
        @(negedge clk); #1 st[0] = 1'b1; bv[0] = 100;
        @(negedge clk); #1 bv[0] = 55;
        @(negedge clk); #1 st[0] = 1'b0;
        @(negedge clk); #1 st[0] = 1'b1;
        @(negedge clk); #1 st[0] = 1'b0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_done[0]) begin nd++; #1 st[0] = 1'b1; end
            else begin #1 st[0] = 1'b0; end
        end
        chk("ign_dones", 0, 64'(nd), 64'd1);
        chk("ign_bcd",   0, 64'(a_bcd[0]), 64'h100);

        // Reset sampled at accept+4 aborts the conversion.
        @(negedge clk); #1 st[0] = 1'b1; bv[0] = 255;
        @(negedge clk); #1 st[0] = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", 0, 64'(a_ready[0]), 64'd1);
        chk("abort_bcd",   0, 64'(a_bcd[0]), 64'd0);
        #1 reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (a_done[0]) nd++;
        end
        chk("abort_dones", 0, 64'(nd), 64'd0);
        run(0, 200, 40'h200, 1'b0, 10'b000);

        // Start held high: back-to-back conversions, each sampling its own bin.
        @(negedge clk); #1 st[1] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1 bv[1] = 32'(c * 7 + 3);
        end
        st[1] = 1'b0;
        repeat (14) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
